// File: rtl/swap_round_engine.sv
// Iterated key-driven bit-swap scrambler: one swap pass per clock over ROUNDS passes,
// with the key rotated left by KEY_ROT between passes, behind valid/ready handshakes.

module swap #(
  parameter int TAG_SIZE        = 4,
  parameter int RECORD_SIZE     = 16,
  parameter int SECRET_KEY_SIZE = 16
) (
  input  logic [RECORD_SIZE-1:0]     i_record,
  input  logic [SECRET_KEY_SIZE-1:0] secret_key,
  output logic [RECORD_SIZE-1:0]     o_record
);
  localparam int NB = RECORD_SIZE / TAG_SIZE;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam int PW = (TAG_SIZE > 1) ? $clog2(TAG_SIZE) : 1;
  localparam int FW = SECRET_KEY_SIZE / 4;

  // Key is four FW-bit fields: {py, s:px, by, bx}, each using its low bits.
  logic [IW-1:0] bx_s, by_s;
  logic [PW-1:0] px_s, py_s, s_s;

  assign bx_s = secret_key[0 +: IW];
  assign by_s = secret_key[FW +: IW];
  assign px_s = secret_key[2*FW +: PW];
  assign s_s  = secret_key[2*FW+PW +: PW];
  assign py_s = secret_key[3*FW +: PW];

  // Swap s bits of block bx (from px) with block by (from py); runs are clipped at the tag edge.
  always_comb begin
    o_record = i_record;
    for (int j = 0; j < TAG_SIZE; j++) begin
      if ((bx_s != by_s) && (j < int'(s_s)) &&
          (int'(px_s) + j < TAG_SIZE) && (int'(py_s) + j < TAG_SIZE) &&
          (int'(bx_s) < NB) && (int'(by_s) < NB)) begin
        o_record[int'(bx_s)*TAG_SIZE + int'(px_s) + j] = i_record[int'(by_s)*TAG_SIZE + int'(py_s) + j];
        o_record[int'(by_s)*TAG_SIZE + int'(py_s) + j] = i_record[int'(bx_s)*TAG_SIZE + int'(px_s) + j];
      end
    end
  end
endmodule

module swap_round_engine #(
  parameter int TAG_SIZE        = 4,
  parameter int RECORD_SIZE     = 16,
  parameter int SECRET_KEY_SIZE = 16,
  parameter int ROUNDS          = 4,
  parameter int KEY_ROT         = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [RECORD_SIZE-1:0]     in_record,
  input  logic [SECRET_KEY_SIZE-1:0] in_key,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [RECORD_SIZE-1:0]     out_record,
  output logic                       busy
);
  localparam int RW = $clog2(ROUNDS + 1);
  localparam int KW = SECRET_KEY_SIZE;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

  state_e                 state_q;
  logic [RECORD_SIZE-1:0] rec_q;
  logic [RECORD_SIZE-1:0] nxt_rec;
  logic [KW-1:0]          key_q;
  logic [KW-1:0]          key_d;
  logic [RW-1:0]          rnd_q;
  logic                   in_ready_q;
  logic                   out_valid_q;
  logic                   busy_q;

  function automatic logic [KW-1:0] rotl(input logic [KW-1:0] k, input int n);
    rotl = (k << n) | (k >> (KW - n));
  endfunction

  swap #(
    .TAG_SIZE       (TAG_SIZE),
    .RECORD_SIZE    (RECORD_SIZE),
    .SECRET_KEY_SIZE(SECRET_KEY_SIZE)
  ) u_swap (
    .i_record  (rec_q),
    .secret_key(key_q),
    .o_record  (nxt_rec)
  );

  assign key_d = rotl(key_q, KEY_ROT);

  // in_ready stays low through reset and comes up on the first edge after release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rec_q       <= '0;
      key_q       <= '0;
      rnd_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            rec_q      <= in_record;
            key_q      <= in_key;
            rnd_q      <= '0;
            state_q    <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          rec_q <= nxt_rec;
          key_q <= key_d;
          rnd_q <= rnd_q + RW'(1);
          if (rnd_q == RW'(ROUNDS - 1)) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign out_record = rec_q;
endmodule

// File: tb/tb_swap_round_engine.sv
// Directed bench: main engine (ROUNDS=4, KEY_ROT=3) plus ROUNDS=1 and ROUNDS=2/KEY_ROT=0 instances.

module tb_swap_round_engine;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic [15:0] a_in_record, a_in_key, a_out_record;

  logic [1:0]       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [1:0][15:0] b_in_record, b_in_key, b_out_record;

  int n_tests = 0;
  int n_fail  = 0;

  swap_round_engine #(.ROUNDS(4), .KEY_ROT(3)) dut (
    .clk(clk), .reset(reset),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_record(a_in_record), .in_key(a_in_key),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_record(a_out_record), .busy(a_busy)
  );

  swap_round_engine #(.ROUNDS(1), .KEY_ROT(3)) dut_r1 (
    .clk(clk), .reset(reset),
    .in_valid(b_in_valid[0]), .in_ready(b_in_ready[0]),
    .in_record(b_in_record[0]), .in_key(b_in_key[0]),
    .out_valid(b_out_valid[0]), .out_ready(b_out_ready[0]),
    .out_record(b_out_record[0]), .busy(b_busy[0])
  );

  swap_round_engine #(.ROUNDS(2), .KEY_ROT(0)) dut_r2 (
    .clk(clk), .reset(reset),
    .in_valid(b_in_valid[1]), .in_ready(b_in_ready[1]),
    .in_record(b_in_record[1]), .in_key(b_in_key[1]),
    .out_valid(b_out_valid[1]), .out_ready(b_out_ready[1]),
    .out_record(b_out_record[1]), .busy(b_busy[1])
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_a(input logic [15:0] r, input logic [15:0] k, input logic [15:0] e, input string tag);
    int n;
    a_in_record = r;
    a_in_key    = k;
    a_in_valid  = 1'b1;
    tick;
    a_in_valid  = 1'b0;
    a_in_record = ~r;
    a_in_key    = ~k;
    n = 0;
    while (!a_out_valid && n < 20) begin
      tick;
      n++;
    end
    chk({tag, "_lat"}, n, 4);
    chk({tag, "_rec"}, {16'h0, a_out_record}, {16'h0, e});
    a_out_ready = 1'b1;
    tick;
    a_out_ready = 1'b0;
    chk({tag, "_drain"}, {31'h0, a_out_valid}, 32'h0);
  endtask

  task automatic run_b(input int d, input logic [15:0] r, input logic [15:0] k,
                       input logic [15:0] e, input int lat, input string tag);
    int n;
    b_in_record[d] = r;
    b_in_key[d]    = k;
    b_in_valid[d]  = 1'b1;
    tick;
    b_in_valid[d]  = 1'b0;
    b_in_record[d] = ~r;
    n = 0;
    while (!b_out_valid[d] && n < 20) begin
      tick;
      n++;
    end
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_rec"}, {16'h0, b_out_record[d]}, {16'h0, e});
    b_out_ready[d] = 1'b1;
    tick;
    b_out_ready[d] = 1'b0;
    chk({tag, "_ready"}, {31'h0, b_in_ready[d]}, 32'h1);
  endtask

  initial begin
    int          n;
    int          n_acc, n_out;
    int          acc_cyc[3];
    logic        will_acc, will_out;
    logic [15:0] recs[3], keys[3], exps[3];

    reset       = 1'b1;
    a_in_valid  = 1'b0;
    a_out_ready = 1'b0;
    a_in_record = 16'h0;
    a_in_key    = 16'h0;
    b_in_valid  = '0;
    b_out_ready = '0;
    b_in_record = '0;
    b_in_key    = '0;

    #1;
    chk("rst_in_ready", {31'h0, a_in_ready}, 32'h0);
    chk("rst_out_valid", {31'h0, a_out_valid}, 32'h0);
    chk("rst_busy", {31'h0, a_busy}, 32'h0);
    chk("rst_out_record", {16'h0, a_out_record}, 32'h0);
    tick;
    tick;
    reset = 1'b0;
    tick;
    chk("post_rst_in_ready", {31'h0, a_in_ready}, 32'h1);

    // Identity key: record passes through unchanged after 4 passes.
    a_in_record = 16'hABCD;
    a_in_key    = 16'h0000;
    a_in_valid  = 1'b1;
    tick;
    a_in_valid  = 1'b0;
    a_in_record = 16'h5555;
    a_in_key    = 16'hFFFF;
    chk("run_busy", {31'h0, a_busy}, 32'h1);
    chk("run_in_ready", {31'h0, a_in_ready}, 32'h0);
    chk("run_out_valid", {31'h0, a_out_valid}, 32'h0);
    n = 0;
    while (!a_out_valid && n < 20) begin
      tick;
      n++;
    end
    chk("ident_lat", n, 4);
    chk("ident_rec", {16'h0, a_out_record}, 32'hABCD);

    // Backpressure: ten stalled cycles, then a single-cycle pulse.
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("bp_rec", {16'h0, a_out_record}, 32'hABCD);
      chk("bp_valid", {31'h0, a_out_valid}, 32'h1);
      chk("bp_in_ready", {31'h0, a_in_ready}, 32'h0);
    end
    a_out_ready = 1'b1;
    tick;
    a_out_ready = 1'b0;
    chk("bp_xfer_valid", {31'h0, a_out_valid}, 32'h0);
    chk("bp_xfer_in_ready", {31'h0, a_in_ready}, 32'h1);
    chk("bp_xfer_busy", {31'h0, a_busy}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("bp_single_xfer", {31'h0, a_out_valid}, 32'h0);
    end

    // Rotated key schedule: 0C10 -> 6080 -> 0403 -> 2018.
    run_a(16'h00F0, 16'h0C10, 16'h1086, "rot4");

    run_b(0, 16'h00F0, 16'h0C10, 16'h0087, 1, "single_pass");
    run_b(0, 16'h1234, 16'h2932, 16'h5034, 1, "single_pass_b");
    run_b(0, 16'h00F0, 16'h0F10, 16'h00E8, 1, "clip_at_tag_edge");
    run_b(1, 16'h00F0, 16'h0C10, 16'h00F0, 2, "involution");

    // Reset during round 2 discards the record.
    a_in_record = 16'hABCD;
    a_in_key    = 16'h0C10;
    a_in_valid  = 1'b1;
    tick;
    a_in_valid  = 1'b0;
    tick;
    tick;
    reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", {31'h0, a_out_valid}, 32'h0);
    chk("mid_rst_busy", {31'h0, a_busy}, 32'h0);
    chk("mid_rst_out_record", {16'h0, a_out_record}, 32'h0);
    chk("mid_rst_in_ready", {31'h0, a_in_ready}, 32'h0);
    tick;
    reset = 1'b0;
    tick;
    chk("mid_rst_recover_ready", {31'h0, a_in_ready}, 32'h1);
    for (int i = 0; i < 8; i++) begin
      tick;
      chk("mid_rst_no_stale", {31'h0, a_out_valid}, 32'h0);
    end
    run_a(16'h00F0, 16'h0C10, 16'h1086, "after_rst");

    // Back-to-back: in_valid and out_ready held high for three records.
    recs[0] = 16'h1111; keys[0] = 16'h0000; exps[0] = 16'h1111;
    recs[1] = 16'h00F0; keys[1] = 16'h0C10; exps[1] = 16'h1086;
    recs[2] = 16'h3333; keys[2] = 16'h0000; exps[2] = 16'h3333;
    n_acc = 0;
    n_out = 0;
    acc_cyc[0] = 0; acc_cyc[1] = 0; acc_cyc[2] = 0;
    a_out_ready = 1'b1;
    a_in_valid  = 1'b1;
    a_in_record = recs[0];
    a_in_key    = keys[0];
    for (int c = 0; c < 60 && n_out < 3; c++) begin
      chk("b2b_exclusive", {31'h0, a_in_ready & a_out_valid}, 32'h0);
      will_acc = a_in_ready & a_in_valid;
      will_out = a_out_valid & a_out_ready;
      if (will_out) begin
        chk("b2b_out_rec", {16'h0, a_out_record}, {16'h0, exps[n_out]});
        n_out++;
      end
      tick;
      if (will_acc && n_acc < 3) begin
        acc_cyc[n_acc] = c;
        n_acc++;
        if (n_acc < 3) begin
          a_in_record = recs[n_acc];
          a_in_key    = keys[n_acc];
        end else begin
          a_in_valid = 1'b0;
        end
      end
    end
    a_out_ready = 1'b0;
    a_in_valid  = 1'b0;
    chk("b2b_n_acc", n_acc, 3);
    chk("b2b_n_out", n_out, 3);
    chk("b2b_gap0", acc_cyc[1] - acc_cyc[0], 6);
    chk("b2b_gap1", acc_cyc[2] - acc_cyc[1], 6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
